fft16_iterative_fwd: RTL and testbench

- Forward 16-point radix-2 decimation-in-time FFT with an iterative architecture: one butterfly per cycle over an in-place register file.
- This is the analysis-side counterpart of the team's ifft16_iterative. It produces the spectra that the IFFT consumes, and it is the golden source for round-trip FFT→IFFT checks.
- It has the same start/done, unpacked-array port style as the IFFT, so the same bench harness and JSON flow drive both blocks.

---
 rtl/fft16_pkg.sv | 42 ++++
 rtl/fft16_iterative_fwd_if.sv | 24 ++
 rtl/fft_bfly_r2.sv | 41 ++++
 rtl/fft16_iterative_fwd.sv | 141 ++++++++++++++
 tb/tb_fft16_iterative_fwd.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, twiddle ROM, state encoding and helpers for the 16-point
// iterative FFT family. The forward FFT and the IFFT both build on these.
package fft16_pkg;

  localparam int N      = 16;
  localparam int DATA_W = 12;
  localparam int GAIN_W = 4;
  localparam int OUT_W  = DATA_W + GAIN_W;
  localparam int TW_W   = 12;
  localparam int FRAC   = TW_W - 2;
  localparam int W      = OUT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMP = 2'd1,
    ST_DONE = 2'd2
  } fft_state_e;

  // Q1.10 twiddles for k = 0..7: W^k = c - j*sn.
  localparam logic signed [TW_W-1:0] TW_COS [0:7] = '{
    12'sd1024, 12'sd946, 12'sd724, 12'sd392,
    12'sd0, -12'sd392, -12'sd724, -12'sd946
  };
  localparam logic signed [TW_W-1:0] TW_SIN [0:7] = '{
    12'sd0, 12'sd392, 12'sd724, 12'sd946,
    12'sd1024, 12'sd946, 12'sd724, 12'sd392
  };

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // W is exactly one bit wider than the output, so overflow shows up as a
  // disagreement between the two top bits.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [W-1:0] v);
    if (v[W-1] != v[W-2]) begin
      return v[W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fft16_iterative_fwd_if.sv
// Start/done handshake and unpacked sample/spectrum arrays of the 16-point FFT.
// start is a request that the block samples only while idle or done; done is a
// level that stays high while the outputs hold a valid spectrum.
interface fft16_iterative_fwd_if;
  import fft16_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] data_real_in  [0:N-1];
  logic signed [DATA_W-1:0] data_imag_in  [0:N-1];
  logic signed [OUT_W-1:0]  data_real_out [0:N-1];
  logic signed [OUT_W-1:0]  data_imag_out [0:N-1];
  logic                     done;

  modport master (
    output start, data_real_in, data_imag_in,
    input  data_real_out, data_imag_out, done
  );

  modport slave (
    input  start, data_real_in, data_imag_in,
    output data_real_out, data_imag_out, done
  );

endinterface

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 DIT butterfly: P = round(B * (c - j*sn)), A' = A + P,
// B' = A - P, all wrapping in W bits. The IFFT reuses it with sn negated.
module fft_bfly_r2
  import fft16_pkg::*;
(
  input  logic signed [W-1:0]    a_re,
  input  logic signed [W-1:0]    a_im,
  input  logic signed [W-1:0]    b_re,
  input  logic signed [W-1:0]    b_im,
  input  logic signed [TW_W-1:0] tw_c,
  input  logic signed [TW_W-1:0] tw_s,
  output logic signed [W-1:0]    top_re,
  output logic signed [W-1:0]    top_im,
  output logic signed [W-1:0]    bot_re,
  output logic signed [W-1:0]    bot_im
);

  localparam int PW = W + TW_W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC - 1));

  logic signed [PW-1:0] br_x, bi_x, c_x, s_x;
  logic signed [PW-1:0] pr_full, pi_full;
  logic signed [W-1:0]  p_re, p_im;

  assign br_x = PW'(b_re);
  assign bi_x = PW'(b_im);
  assign c_x  = PW'(tw_c);
  assign s_x  = PW'(tw_s);

  // Round half up, then drop the Q1.10 fraction.
  assign pr_full = br_x * c_x + bi_x * s_x + HALF;
  assign pi_full = bi_x * c_x - br_x * s_x + HALF;
  assign p_re    = W'(pr_full >>> FRAC);
  assign p_im    = W'(pi_full >>> FRAC);

  assign top_re = a_re + p_re;
  assign top_im = a_im + p_im;
  assign bot_re = a_re - p_re;
  assign bot_im = a_im - p_im;

endmodule

// File: rtl/fft16_iterative_fwd.sv
// Forward 16-point radix-2 DIT FFT, one butterfly per clock over an in-place
// register file; saturated spectrum appears 33 cycles after start is accepted.
module fft16_iterative_fwd #(
  parameter int N      = 16,
  parameter int DATA_W = 12,
  parameter int GAIN_W = 4,
  parameter int TW_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  fft16_iterative_fwd_if.slave  bus,
  output fft16_pkg::fft_state_e dbg_state
);
  import fft16_pkg::*;

  if (N != 16 || DATA_W != fft16_pkg::DATA_W || GAIN_W != fft16_pkg::GAIN_W ||
      TW_W != fft16_pkg::TW_W) begin : g_cfg_check
    $error("fft16_iterative_fwd supports only N=16 with the fft16_pkg widths");
  end

  typedef logic signed [W-1:0] word_t;

  fft_state_e state, state_nx;
  logic [5:0] cnt;
  logic       capture, step, finish;
  word_t      mem_re [0:N-1];
  word_t      mem_im [0:N-1];

  logic [1:0] stage;
  logic [2:0] bfly;
  logic [3:0] top_idx, bot_idx;
  logic [2:0] tw_idx;
  word_t      top_re, top_im, bot_re, bot_im;

  // cnt 0..31 walks the 32 butterflies; cnt == 32 is the output-copy cycle.
  assign stage = cnt[4:3];
  assign bfly  = cnt[2:0];

  // top = ((b>>s)<<(s+1)) + (b & (h-1)), bot = top + h, k = (b & (h-1)) << (3-s)
  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    tw_idx  = '0;
    case (stage)
      2'd0: begin
        top_idx = {bfly, 1'b0};
        bot_idx = {bfly, 1'b1};
        tw_idx  = 3'd0;
      end
      2'd1: begin
        top_idx = {bfly[2:1], 1'b0, bfly[0]};
        bot_idx = {bfly[2:1], 1'b1, bfly[0]};
        tw_idx  = {bfly[0], 2'b00};
      end
      2'd2: begin
        top_idx = {bfly[2], 1'b0, bfly[1:0]};
        bot_idx = {bfly[2], 1'b1, bfly[1:0]};
        tw_idx  = {bfly[1:0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, bfly};
        bot_idx = {1'b1, bfly};
        tw_idx  = bfly;
      end
    endcase
  end

  fft_bfly_r2 u_bfly (
    .a_re   (mem_re[top_idx]),
    .a_im   (mem_im[top_idx]),
    .b_re   (mem_re[bot_idx]),
    .b_im   (mem_im[bot_idx]),
    .tw_c   (TW_COS[tw_idx]),
    .tw_s   (TW_SIN[tw_idx]),
    .top_re (top_re),
    .top_im (top_im),
    .bot_re (bot_re),
    .bot_im (bot_im)
  );

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nx = ST_COMP;
          capture  = 1'b1;
        end
      end
      ST_COMP: begin
        if (cnt == 6'd32) begin
          state_nx = ST_DONE;
          finish   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      for (int i = 0; i < N; i++) begin
        mem_re[i]            <= '0;
        mem_im[i]            <= '0;
        bus.data_real_out[i] <= '0;
        bus.data_imag_out[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (capture) begin
        cnt <= '0;
        for (int n = 0; n < N; n++) begin
          mem_re[bitrev4(4'(n))] <= word_t'(bus.data_real_in[n]);
          mem_im[bitrev4(4'(n))] <= word_t'(bus.data_imag_in[n]);
        end
      end else if (step) begin
        cnt             <= cnt + 6'd1;
        mem_re[top_idx] <= top_re;
        mem_im[top_idx] <= top_im;
        mem_re[bot_idx] <= bot_re;
        mem_im[bot_idx] <= bot_im;
      end else if (finish) begin
        for (int i = 0; i < N; i++) begin
          bus.data_real_out[i] <= saturate(mem_re[i]);
          bus.data_imag_out[i] <= saturate(mem_im[i]);
        end
      end
    end
  end

  assign bus.done  = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fft16_iterative_fwd.sv
// Directed bench for fft16_iterative_fwd: table of spectra with tolerances plus
// hand-written control sequences (ignored start, mid-transform reset, restart).
module tb_fft16_iterative_fwd;
  import fft16_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft16_iterative_fwd_if bus();
  fft_state_e dbg_state;

  fft16_iterative_fwd #(.N(16), .DATA_W(12), .GAIN_W(4), .TW_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // tr/ti < 0 means that bin is not checked
  typedef struct {
    int xr[16];
    int xi[16];
    int er[16];
    int ei[16];
    int tr[16];
    int ti[16];
  } vec_t;

  localparam int NV = 5;
  localparam real PI = 3.14159265358979;
  vec_t  vecs[NV];
  string vname[NV] = '{"impulse", "dc", "tone", "sat", "random"};
  int    tone_tab[16] = '{1000, 924, 707, 383, 0, -383, -707, -924,
                          -1000, -924, -707, -383, 0, 383, 707, 924};

  // scoreboard: expected start-to-done latency per transform
  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string what, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", what, act, exp, tol);
    end
  endtask

  function automatic int nonzero_outputs();
    int cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.data_real_out[k] != 0) cnt++;
      if (bus.data_imag_out[k] != 0) cnt++;
    end
    return cnt;
  endfunction

  task automatic init_table();
    for (int v = 0; v < NV; v++) begin
      for (int n = 0; n < 16; n++) begin
        vecs[v].xr[n] = 0; vecs[v].xi[n] = 0;
        vecs[v].er[n] = 0; vecs[v].ei[n] = 0;
        vecs[v].tr[n] = -1; vecs[v].ti[n] = -1;
      end
    end
    // impulse: flat spectrum, exact
    vecs[0].xr[0] = 1000;
    for (int k = 0; k < 16; k++) begin
      vecs[0].er[k] = 1000; vecs[0].tr[k] = 0; vecs[0].ti[k] = 0;
    end
    // dc: exact X[0], others within 2
    for (int n = 0; n < 16; n++) begin
      vecs[1].xr[n] = 100; vecs[1].tr[n] = 2; vecs[1].ti[n] = 2;
    end
    vecs[1].er[0] = 1600; vecs[1].tr[0] = 0; vecs[1].ti[0] = 0;
    // tone: bins 1 and 15 near 8001, others near 0
    for (int n = 0; n < 16; n++) begin
      vecs[2].xr[n] = tone_tab[n]; vecs[2].tr[n] = 4; vecs[2].ti[n] = 4;
    end
    vecs[2].er[1] = 8001; vecs[2].tr[1] = 8;
    vecs[2].er[15] = 8001; vecs[2].tr[15] = 8;
    // saturation: X[1].re ~ 41175 clips, X[0] = 4087+4087j exact
    for (int n = 0; n < 16; n++) begin
      vecs[3].xr[n] = (n <= 4 || n >= 12) ? 2047 : -2048;
      vecs[3].xi[n] = (n <= 8) ? 2047 : -2048;
    end
    vecs[3].er[0] = 4087; vecs[3].ei[0] = 4087; vecs[3].tr[0] = 0; vecs[3].ti[0] = 0;
    vecs[3].er[1] = 32767; vecs[3].tr[1] = 0;
    // random: floating-point DFT reference
    for (int n = 0; n < 16; n++) begin
      vecs[4].xr[n] = int'($urandom_range(0, 2000)) - 1000;
      vecs[4].xi[n] = int'($urandom_range(0, 2000)) - 1000;
    end
    for (int k = 0; k < 16; k++) begin
      real sr, si, a;
      sr = 0.0; si = 0.0;
      for (int n = 0; n < 16; n++) begin
        a  = 2.0 * PI * real'(n * k) / 16.0;
        sr = sr + vecs[4].xr[n] * $cos(a) + vecs[4].xi[n] * $sin(a);
        si = si + vecs[4].xi[n] * $cos(a) - vecs[4].xr[n] * $sin(a);
      end
      vecs[4].er[k] = int'(sr); vecs[4].ei[k] = int'(si);
      vecs[4].tr[k] = 8; vecs[4].ti[k] = 8;
    end
  endtask

  // driver tasks
  task automatic load_vec(input int v);
    for (int n = 0; n < 16; n++) begin
      bus.data_real_in[n] = 12'(vecs[v].xr[n]);
      bus.data_imag_in[n] = 12'(vecs[v].xi[n]);
    end
  endtask

  task automatic check_vec(input int v);
    for (int k = 0; k < 16; k++) begin
      if (vecs[v].tr[k] >= 0)
        check($sformatf("%s X[%0d].re", vname[v], k), int'(bus.data_real_out[k]),
              vecs[v].er[k], vecs[v].tr[k]);
      if (vecs[v].ti[k] >= 0)
        check($sformatf("%s X[%0d].im", vname[v], k), int'(bus.data_imag_out[k]),
              vecs[v].ei[k], vecs[v].ti[k]);
    end
  endtask

  task automatic wait_done(input string tag, input int cyc_in);
    int cyc;
    cyc = cyc_in;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, int'(exp_q.pop_front()), 0);
  endtask

  task automatic start_and_wait(input string tag);
    exp_q.push_back(6'd33);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done low after start"}, int'(bus.done), 0, 0);
    wait_done(tag, 0);
  endtask

  initial begin
    int cyc;
    init_table();
    rst = 1'b1;
    bus.start = 1'b0;
    load_vec(0);
    repeat (3) @(negedge clk);

    check("reset done", int'(bus.done), 0, 0);
    check("reset state", int'(dbg_state), int'(ST_IDLE), 0);
    check("reset outputs nonzero count", nonzero_outputs(), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      start_and_wait(vname[v]);
      check_vec(v);
    end

    // start (with different inputs) at cycle 10 of COMP must be ignored
    load_vec(0);
    exp_q.push_back(6'd33);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    repeat (9) begin @(negedge clk); cyc++; end
    bus.start = 1'b1;
    for (int n = 0; n < 16; n++) begin
      bus.data_real_in[n] = 12'sd555;
      bus.data_imag_in[n] = -12'sd300;
    end
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    check("stray start state", int'(dbg_state), int'(ST_COMP), 0);
    wait_done("stray start", cyc);
    check_vec(0);

    // reset at cycle 20 of COMP discards the transform
    load_vec(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset done", int'(bus.done), 0, 0);
    check("mid reset state", int'(dbg_state), int'(ST_IDLE), 0);
    check("mid reset outputs nonzero count", nonzero_outputs(), 0, 0);
    load_vec(2);
    start_and_wait("after reset");
    check_vec(2);

    // restart from DONE: done falls, old spectrum held until the new one lands
    load_vec(1);
    exp_q.push_back(6'd33);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart done low", int'(bus.done), 0, 0);
    check("restart state", int'(dbg_state), int'(ST_COMP), 0);
    check("restart held X[1].re", int'(bus.data_real_out[1]), 8001, 8);
    wait_done("restart", 0);
    check_vec(1);

    check("latency queue drained", exp_q.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
